irrigation_minutes_countdown: RTL

- Downstream stage of the units-of-seconds down counter in the irrigation timer.
- Consumes that counter's one-cycle wrap strobe (units 0->9).
- Counts down the tens-of-seconds digit (0-5) and two BCD minutes digits (00-99).
- Drives the stop and zero feedback to the units stage, plus the irrigation valve enable and a completion pulse, to the top-level controller.

---
 rtl/irrigation_timer_pkg.sv | 16 +
 rtl/irrigation_minutes_countdown_if.sv | 30 +++
 rtl/irrigation_minutes_countdown_bcd_down_digit.sv | 31 +++
 rtl/irrigation_minutes_countdown.sv | 98 +++++++++
 4 files changed

// File: rtl/irrigation_timer_pkg.sv
// irrigation_timer_pkg: shared state encoding, BCD constants and preset validation
package irrigation_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam int BCD_W            = 4;
    localparam int BCD_MAX          = 9;
    localparam int SEC_TENS_MOD_DEF = 6;
    localparam int MIN_MOD_DEF      = 10;

    // A preset is usable only if both nibbles are decimal and it is not 00
    function automatic logic preset_ok(input logic [2*BCD_W-1:0] p);
        return (p[7:4] <= BCD_W'(BCD_MAX)) && (p[3:0] <= BCD_W'(BCD_MAX)) && (p != '0);
    endfunction

endpackage

// File: rtl/irrigation_minutes_countdown_if.sv
// irrigation_minutes_countdown_if: control, feedback and display signals of the minutes stage
interface irrigation_minutes_countdown_if;
    import irrigation_timer_pkg::*;

    logic               start;
    logic               abort;
    logic [2*BCD_W-1:0] preset_min;
    logic               pause;
    logic               units_zero;
    logic               borrow_in;
    logic               run_en;
    logic               reach_zero;
    logic [BCD_W-1:0]   sec_tens;
    logic [BCD_W-1:0]   min_units;
    logic [BCD_W-1:0]   min_tens;
    logic               valve_on;
    logic               done;
    logic               load_err;

    modport master (
        output start, abort, preset_min, pause, units_zero, borrow_in,
        input  run_en, reach_zero, sec_tens, min_units, min_tens, valve_on, done, load_err
    );

    modport slave (
        input  start, abort, preset_min, pause, units_zero, borrow_in,
        output run_en, reach_zero, sec_tens, min_units, min_tens, valve_on, done, load_err
    );

endinterface

// File: rtl/irrigation_minutes_countdown_bcd_down_digit.sv
// bcd_down_digit: one loadable modulo-MOD down-counting digit with borrow output
module bcd_down_digit
    import irrigation_timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec,
    output logic [BCD_W-1:0] value,
    output logic             borrow_out
);

    logic [BCD_W-1:0] value_q;

    // Load wins over decrement; a decrement from 0 wraps to MOD-1
    always_ff @(posedge clk) begin
        if (clear)
            value_q <= '0;
        else if (load)
            value_q <= load_val;
        else if (dec)
            value_q <= (value_q == '0) ? BCD_W'(MOD - 1) : value_q - 1'b1;
    end

    assign value      = value_q;
    assign borrow_out = dec & (value_q == '0);

endmodule

// File: rtl/irrigation_minutes_countdown.sv
// irrigation_minutes_countdown: tens-of-seconds and BCD minutes countdown with valve control
module irrigation_minutes_countdown
    import irrigation_timer_pkg::*;
#(
    parameter int SEC_TENS_MOD = SEC_TENS_MOD_DEF,
    parameter int MIN_MOD      = MIN_MOD_DEF
) (
    input  logic                            clk,
    input  logic                            clear,
    irrigation_minutes_countdown_if.slave   bus
);

    state_t           state_q, state_d;
    logic             valve_q, done_q, done_d, load_err_q, load_err_d;
    logic             upper_zero, abort_ok, start_req, start_ok, load, dec_st;
    logic             b_st, b_mu, b_mt;
    logic [BCD_W-1:0] st, mu, mt, ld_mu, ld_mt;

    assign upper_zero     = (st == '0) && (mu == '0) && (mt == '0);
    assign bus.reach_zero = bus.units_zero & upper_zero;
    assign bus.run_en     = (state_q == RUN) & ~bus.pause & ~bus.reach_zero;

    // abort only acts outside IDLE but always masks a same-cycle start
    assign abort_ok  = bus.abort & (state_q != IDLE);
    assign start_req = ~bus.abort & bus.start & ((state_q == IDLE) || (state_q == DONE));
    assign start_ok  = start_req & preset_ok(bus.preset_min);
    assign load      = abort_ok | start_ok;
    assign ld_mu     = abort_ok ? '0 : bus.preset_min[3:0];
    assign ld_mt     = abort_ok ? '0 : bus.preset_min[7:4];

    // Borrows at 00:0x are dropped so the digits rest at zero instead of wrapping
    assign dec_st = (state_q == RUN) & ~bus.pause & bus.borrow_in & ~upper_zero;

    bcd_down_digit #(.MOD(SEC_TENS_MOD)) u_sec_tens (
        .clk(clk), .clear(clear), .load(load), .load_val('0),
        .dec(dec_st), .value(st), .borrow_out(b_st)
    );

    bcd_down_digit #(.MOD(MIN_MOD)) u_min_units (
        .clk(clk), .clear(clear), .load(load), .load_val(ld_mu),
        .dec(b_st), .value(mu), .borrow_out(b_mu)
    );

    bcd_down_digit #(.MOD(MIN_MOD)) u_min_tens (
        .clk(clk), .clear(clear), .load(load), .load_val(ld_mt),
        .dec(b_mu), .value(mt), .borrow_out(b_mt)
    );

    // Next state in priority order: abort, start, completion, pause/resume
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (abort_ok)
            state_d = IDLE;
        else if (start_req)
            if (start_ok)
                state_d = RUN;
            else
                load_err_d = 1'b1;
        else if ((state_q == RUN) && bus.reach_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
        end
        else if ((state_q == RUN) && bus.pause)
            state_d = PAUSED;
        else if ((state_q == PAUSED) && !bus.pause)
            state_d = RUN;
    end

    // State and registered outputs; the valve tracks the state being entered
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            valve_q    <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valve_q    <= (state_d == RUN);
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Minutes tens never wraps: the zero detect halts the chain before it can
    always_comb begin
        assert (!b_mt || clear);
    end

    assign bus.sec_tens  = st;
    assign bus.min_units = mu;
    assign bus.min_tens  = mt;
    assign bus.valve_on  = valve_q;
    assign bus.done      = done_q;
    assign bus.load_err  = load_err_q;

endmodule
